// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing one SD sector reader among NREQ loaders.
// It grants one requester, launches its read, forwards the indexed bytes, then reports done or err.
module sd_sector_arbiter #(
    parameter int NREQ       = 2,
    parameter int TIMEOUT    = 2000000,
    parameter int SECT_BYTES = 512
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*32-1:0] req_addr,
    output logic [NREQ-1:0]    grant,
    output logic               rd_stb,
    output logic [7:0]         rd_byte,
    output logic [8:0]         rd_index,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    output logic               fault,
    input  logic               sd_idle,
    output logic               sd_begin_read,
    output logic [31:0]        sd_addr,
    input  logic               sd_byte_stb,
    input  logic [7:0]         sd_byte
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [9:0]      LAST_BYTE = 10'(SECT_BYTES - 1);
    localparam logic [NREQ-1:0] ONE       = NREQ'(1);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_BUSY  = 3'd3;
    localparam logic [2:0] S_XFER  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    logic [2:0]    state;
    logic [IW-1:0] rr;
    logic [IW-1:0] owner;
    logic [IW-1:0] winner;
    logic [31:0]   win_addr;
    logic [CW-1:0] tcnt;
    logic [9:0]    count;
    logic          timed_out;
    logic          last_byte;
    logic          fail;

    // First set request at or after the round-robin pointer, wrapping at NREQ-1.
    function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r, input logic [IW-1:0] start);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = start;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(start) + k) % NREQ;
            if (!found && r[IW'(idx)]) begin
                w     = IW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
    endfunction

    assign winner    = pick(req, rr);
    assign timed_out = (tcnt == TO_LAST);
    assign last_byte = sd_byte_stb && (count == LAST_BYTE);

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IW'(i)) win_addr = req_addr[32*i +: 32];
        end
    end

    // A final byte arriving together with a timeout or early idle still completes the sector.
    always_comb begin
        fail = 1'b0;
        if (state == S_BUSY) fail = timed_out;
        else if (state == S_XFER && !last_byte) fail = sd_idle || timed_out;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= S_INIT;
            grant         <= '0;
            rd_stb        <= 1'b0;
            rd_byte       <= '0;
            rd_index      <= '0;
            done          <= '0;
            err           <= '0;
            fault         <= 1'b0;
            sd_begin_read <= 1'b0;
            sd_addr       <= '0;
            rr            <= '0;
            owner         <= '0;
            tcnt          <= '0;
            count         <= '0;
        end else begin
            rd_stb        <= 1'b0;
            done          <= '0;
            err           <= '0;
            sd_begin_read <= 1'b0;
            if (state == S_XFER && sd_byte_stb) begin
                rd_stb   <= 1'b1;
                rd_byte  <= sd_byte;
                rd_index <= count[8:0];
                count    <= count + 10'd1;
            end
            if (fail) begin
                err   <= grant;
                fault <= 1'b1;
                grant <= '0;
                state <= S_FAULT;
            end else begin
                case (state)
                    S_INIT: if (sd_idle) state <= S_IDLE;
                    S_IDLE: begin
                        grant <= '0;
                        if (|req && sd_idle) begin
                            grant   <= ONE << winner;
                            owner   <= winner;
                            sd_addr <= win_addr;
                            state   <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        sd_begin_read <= 1'b1;
                        tcnt          <= '0;
                        count         <= '0;
                        state         <= S_BUSY;
                    end
                    S_BUSY: begin
                        tcnt <= tcnt + 1'b1;
                        if (!sd_idle) state <= S_XFER;
                    end
                    S_XFER: begin
                        tcnt <= tcnt + 1'b1;
                        if (last_byte) begin
                            done  <= grant;
                            rr    <= next_idx(owner);
                            state <= S_IDLE;
                        end
                    end
                    S_FAULT: ;
                    default: state <= S_INIT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Bench for sd_sector_arbiter: directed table of arbitration rounds, randomized traffic
// against a transaction-level model, and reset / short-read / timeout sequences.
module tb_sd_sector_arbiter;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 1500;
    localparam int SB      = 512;

    logic               clock = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ-1:0]    grant;
    logic               rd_stb;
    logic [7:0]         rd_byte;
    logic [8:0]         rd_index;
    logic [NREQ-1:0]    done;
    logic [NREQ-1:0]    err;
    logic               fault;
    logic               sd_idle;
    logic               sd_begin_read;
    logic [31:0]        sd_addr;
    logic               sd_byte_stb;
    logic [7:0]         sd_byte;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  eg;
        logic [31:0] ea;
    } vec_t;
    vec_t tbl [6];

    sd_sector_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .SECT_BYTES(SB)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_addr(req_addr), .grant(grant),
        .rd_stb(rd_stb), .rd_byte(rd_byte), .rd_index(rd_index), .done(done), .err(err),
        .fault(fault), .sd_idle(sd_idle), .sd_begin_read(sd_begin_read), .sd_addr(sd_addr),
        .sd_byte_stb(sd_byte_stb), .sd_byte(sd_byte)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Round-robin rule: first pending requester at or after the pointer.
    function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic perturb(input int own);
        for (int i = 0; i < NREQ; i++) begin
            if (i != own && !req[i] && $urandom_range(0, 15) == 0) begin
                req[i] = 1'b1;
                req_addr[32*i +: 32] = $urandom;
            end
            if (i == own && req[i] && $urandom_range(0, 63) == 0) req[i] = 1'b0;
            if (i == own && $urandom_range(0, 31) == 0) req_addr[32*i +: 32] = $urandom;
        end
    endtask

    // Waits for a new grant, then checks the address and the begin_read pulse one cycle later.
    task automatic await_grant(input logic [NREQ-1:0] exp_oh, input logic [31:0] exp_addr, input int exp_lat);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (grant === '0 && n < 20);
        if (exp_lat > 0) check("grant_latency", 64'(n), 64'(exp_lat));
        check("grant", 64'(grant), 64'(exp_oh));
        check("sd_addr", 64'(sd_addr), 64'(exp_addr));
        check("begin_read_early", 64'(sd_begin_read), 64'(0));
        step();
        check("begin_read", 64'(sd_begin_read), 64'(1));
        check("grant_hold", 64'(grant), 64'(exp_oh));
    endtask

    // Acts as the SD reader: goes busy, strobes nbytes, checks each forwarded byte one cycle later.
    task automatic stream(input int nbytes, input int own, input logic [31:0] addr, input bit rnd, input bit exp_done);
        logic [NREQ-1:0] oh;
        int sent, got, dly, cyc, pidx;
        bit pstb;
        logic [7:0] pbyte;
        oh = '0;
        oh[own] = 1'b1;
        sent = 0; got = 0; cyc = 0; pstb = 0; pbyte = '0; pidx = 0;
        dly = rnd ? int'($urandom_range(0, 2)) : 0;
        sd_idle = 1'b0;
        sd_byte_stb = 1'b0;
        while (got < nbytes && cyc < nbytes * 3 + 20) begin
            step();
            cyc++;
            check("rd_stb", 64'(rd_stb), 64'(pstb));
            if (pstb) begin
                check("rd_index", 64'(rd_index), 64'(pidx));
                check("rd_byte", 64'(rd_byte), 64'(pbyte));
                got++;
            end
            check("done", 64'(done), 64'((pstb && pidx == SB - 1 && exp_done) ? oh : '0));
            check("grant_own", 64'(grant), 64'(oh));
            check("sd_addr_hold", 64'(sd_addr), 64'(addr));
            check("err_quiet", 64'({fault, err}), 64'(0));
            if (got == nbytes) break;
            pstb = 1'b0;
            if (dly > 0) dly--;
            else if (sent < nbytes && (!rnd || $urandom_range(0, 3) != 0)) begin
                pstb = 1'b1;
                pidx = sent;
                pbyte = rnd ? 8'($urandom) : 8'(sent);
                sent++;
            end
            sd_byte_stb = pstb;
            sd_byte = pbyte;
            if (rnd) perturb(own);
        end
        sd_byte_stb = 1'b0;
        check("bytes_delivered", 64'(got), 64'(nbytes));
    endtask

    initial begin
        int rr_model, w, k;
        logic [31:0] ea;
        logic [1:0] s;
        logic [NREQ-1:0] oh;

        tbl[0] = '{2'b11, 32'h0000_1000, 32'h0000_2001, 2'b10, 32'h0000_2001};
        tbl[1] = '{2'b11, 32'h0000_1110, 32'h0000_2111, 2'b01, 32'h0000_1110};
        tbl[2] = '{2'b01, 32'h0000_1220, 32'h0000_2221, 2'b01, 32'h0000_1220};
        tbl[3] = '{2'b10, 32'h0000_1330, 32'h0000_2331, 2'b10, 32'h0000_2331};
        tbl[4] = '{2'b10, 32'h0000_1440, 32'h0000_2441, 2'b10, 32'h0000_2441};
        tbl[5] = '{2'b11, 32'h0000_1550, 32'h0000_2551, 2'b01, 32'h0000_1550};

        reset_n = 1'b0; req = '0; req_addr = '0; sd_idle = 1'b0; sd_byte_stb = 1'b0; sd_byte = '0;
        repeat (3) step();
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_rd_stb", 64'(rd_stb), 64'(0));
        check("rst_rd_byte", 64'(rd_byte), 64'(0));
        check("rst_rd_index", 64'(rd_index), 64'(0));
        check("rst_done_err", 64'({done, err}), 64'(0));
        check("rst_fault", 64'(fault), 64'(0));
        check("rst_begin_read", 64'(sd_begin_read), 64'(0));
        check("rst_sd_addr", 64'(sd_addr), 64'(0));

        // Card still initialising: a request must not be granted.
        reset_n = 1'b1;
        req = 2'b01;
        req_addr[31:0] = 32'hA5A5_0001;
        for (int i = 0; i < 20; i++) begin
            step();
            check("init_no_grant", 64'({grant, sd_begin_read}), 64'(0));
        end
        sd_idle = 1'b1;
        await_grant(2'b01, 32'hA5A5_0001, 2);
        stream(SB, 0, 32'hA5A5_0001, 1'b0, 1'b1);
        sd_idle = 1'b1;
        req = tbl[0].req;
        req_addr = {tbl[0].a1, tbl[0].a0};

        for (int i = 0; i < 6; i++) begin
            await_grant(tbl[i].eg, tbl[i].ea, 1);
            stream(SB, (tbl[i].eg == 2'b10) ? 1 : 0, tbl[i].ea, 1'b0, 1'b1);
            sd_idle = 1'b1;
            if (i < 5) begin
                req = tbl[i+1].req;
                req_addr = {tbl[i+1].a1, tbl[i+1].a0};
            end
        end

        // Reset during byte 200; afterwards the pointer must restart at requester 0.
        req = 2'b11;
        req_addr = {32'h6666_0001, 32'h6666_0000};
        await_grant(2'b10, 32'h6666_0001, 1);
        stream(200, 1, 32'h6666_0001, 1'b0, 1'b0);
        sd_byte_stb = 1'b1;
        sd_byte = 8'hC8;
        reset_n = 1'b0;
        step();
        check("rst6_grant", 64'(grant), 64'(0));
        check("rst6_rd_stb", 64'(rd_stb), 64'(0));
        check("rst6_outs", 64'({done, err, fault, sd_begin_read, rd_index, rd_byte}), 64'(0));
        check("rst6_sd_addr", 64'(sd_addr), 64'(0));
        sd_byte_stb = 1'b0;
        sd_idle = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst6_init_wait", 64'({grant, sd_begin_read}), 64'(0));
        end
        sd_idle = 1'b1;
        await_grant(2'b01, 32'h6666_0000, 2);
        stream(SB, 0, 32'h6666_0000, 1'b0, 1'b1);
        sd_idle = 1'b1;
        req[0] = 1'b0;
        rr_model = 1;

        for (int t = 0; t < 6 && errors < 40; t++) begin
            if (req == '0) begin
                s = 2'($urandom_range(1, 3));
                for (int i = 0; i < NREQ; i++) begin
                    if (s[i]) begin
                        req[i] = 1'b1;
                        req_addr[32*i +: 32] = $urandom;
                    end
                end
            end
            w = model_pick(req, rr_model);
            ea = req_addr[32*w +: 32];
            oh = '0;
            oh[w] = 1'b1;
            await_grant(oh, ea, 1);
            stream(SB, w, ea, 1'b1, 1'b1);
            sd_idle = 1'b1;
            req[w] = 1'b0;
            rr_model = (w + 1) % NREQ;
        end

        // Reader returns idle after 300 bytes: short read.
        req = req | 2'b01;
        w = model_pick(req, rr_model);
        ea = req_addr[32*w +: 32];
        oh = '0;
        oh[w] = 1'b1;
        await_grant(oh, ea, 1);
        stream(300, w, ea, 1'b0, 1'b0);
        sd_idle = 1'b1;
        step();
        check("short_err", 64'(err), 64'(oh));
        check("short_fault", 64'(fault), 64'(1));
        check("short_grant", 64'(grant), 64'(0));
        check("short_no_done", 64'({done, rd_stb}), 64'(0));
        req = 2'b11;
        for (int i = 0; i < 20; i++) begin
            step();
            check("fault_ignores_req", 64'({grant, sd_begin_read, err, fault}), 64'(1));
        end

        // Reader accepts but never delivers a byte.
        reset_n = 1'b0;
        req = '0;
        repeat (2) step();
        check("rst4_fault_clear", 64'({fault, err, grant}), 64'(0));
        reset_n = 1'b1;
        req = 2'b01;
        req_addr[31:0] = 32'hDEAD_0004;
        await_grant(2'b01, 32'hDEAD_0004, 2);
        sd_idle = 1'b0;
        k = 0;
        do begin
            step();
            k++;
        end while (err === '0 && k < TIMEOUT + 10);
        check("timeout_cycle", 64'(k), 64'(TIMEOUT));
        check("timeout_err", 64'(err), 64'(2'b01));
        check("timeout_fault", 64'(fault), 64'(1));
        check("timeout_grant", 64'({grant, done}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
